nrzi_encoder: RTL and testbench
===============================

NRZI_ENCODER -- requirements
Module: nrzi_encoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset, named as below; reset polarity and synchronicity are fixed.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_b  input  1  asynchronous active-low reset.
REQ-004 bstr_in  input  1  stuffed serial data bit from the bit-stuffing stage.
REQ-005 bstr_in_ready  input  2  packet type of bstr_in; 2'b00 = no bit this cycle, nonzero = bstr_in valid.
REQ-006 dp  output  1  USB D+ line, registered.
REQ-007 dm  output  1  USB D- line, registered.
REQ-008 busy  output  1  high while in DATA or any EOP state.
REQ-009 done  output  1  one-cycle pulse when EOP completes.
REQ-010 overrun  output  1  sticky: valid input arrived during EOP.
REQ-011 stuff_err  output  1  sticky: stuffing violation detected (see Configuration).

Function
REQ-012 Line states: J = (dp=1,dm=0), K = (dp=0,dm=1), SE0 = (dp=0,dm=0); dp=dm=1 SHALL never be driven.
REQ-013 FSM states: IDLE, DATA, EOP1, EOP2, EOP_J.
REQ-014 IDLE: drive J; on a cycle with bstr_in_ready != 0, encode that bit and go to DATA.
REQ-015 NRZI encoding: bit 0 toggles the line state (J<->K), bit 1 holds it; the first bit is encoded relative to J.
REQ-016 Latency: the line state for a bit sampled at edge N SHALL appear on dp/dm after edge N (one register stage).
REQ-017 DATA: each cycle with bstr_in_ready != 0 encodes one bit; the first cycle with bstr_in_ready == 0 moves to EOP1.
REQ-018 EOP1 and EOP2 SHALL each drive SE0 for one cycle; EOP_J SHALL drive J for one cycle, then return to IDLE with done=1 for that transition cycle.
REQ-019 Valid input during EOP1/EOP2/EOP_J SHALL be dropped and SHALL set overrun; overrun clears only on reset.
REQ-020 A bstr_in_ready value change between nonzero types inside DATA SHALL NOT end the packet.
REQ-021 A valid bit in the IDLE cycle immediately after EOP_J SHALL start a new packet normally.
REQ-022 busy SHALL be 1 in DATA, EOP1, EOP2, and EOP_J, and 0 in IDLE.

Reset
REQ-023 While rst_b=0: state=IDLE, dp=1, dm=0, busy=0, done=0, overrun=0, stuff_err=0, ones counter=0.
REQ-024 Reset asserted mid-packet or mid-EOP SHALL abort immediately to the reset values, with no EOP emitted.

Configuration
REQ-025 Macro NRZI_STUFF_CHECK_EN: when defined, a 3-bit run counter SHALL count consecutive encoded 1 bits, clear on a 0 bit or on entry to IDLE, and set stuff_err on the 7th consecutive 1.
REQ-026 Once set, stuff_err SHALL stay set until reset.
REQ-027 Without NRZI_STUFF_CHECK_EN, stuff_err SHALL be tied 0 and no run-counter logic SHALL exist.

Structure
REQ-028 Shared package usb_pkg SHALL hold the pkt_type_t enum (2 bits, NONE=2'b00), the line-state constants J/K/SE0, and the FSM state enum.
REQ-029 The run counter SHALL be a sub-module named stuff_checker, instantiated only under NRZI_STUFF_CHECK_EN.

Verification
REQ-030 Reset, then bits 0,0,1,0 with ready=2'b01, then ready=0 -> dp/dm = K,J,J,K, then SE0,SE0,J; done pulses once; busy falls with done.
REQ-031 Valid bit with ready=2'b10 during EOP1 -> bit dropped, EOP timing unchanged, overrun=1 and held through the next packet.
REQ-032 rst_b pulled low during EOP2 -> dp=1, dm=0, busy=0 asynchronously; no done pulse.
REQ-033 With NRZI_STUFF_CHECK_EN, seven consecutive 1s -> stuff_err=1 on the 7th bit; six 1s then a 0 -> stuff_err stays 0.
REQ-034 Back-to-back packets (new valid bit in the IDLE cycle after EOP_J) -> the second packet's first bit is encoded from J; two done pulses total.
REQ-035 A random 64-bit stuffed stream -> an NRZI decode of dp/dm SHALL reproduce the input stream exactly, and dp=dm=1 SHALL never occur.

Source files
------------

// File: rtl/usb_pkg.sv
// ==== usb_pkg : shared USB line-state constants, packet-type and encoder FSM enums. rev 1.0 ====
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    NONE     = 2'b00,
    TOKEN    = 2'b01,
    DATA_PKT = 2'b10,
    HSHAKE   = 2'b11
  } pkt_type_t;

  // Line states packed as {dp, dm}
  localparam logic [1:0] J   = 2'b10;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] SE0 = 2'b00;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    EOP1  = 3'd2,
    EOP2  = 3'd3,
    EOP_J = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/stuff_checker.sv
// ==== stuff_checker : counts consecutive encoded 1s, sticky flag on the 7th. rev 1.0 ====
// Compiled only when NRZI_STUFF_CHECK_EN is defined.
`default_nettype none

`ifdef NRZI_STUFF_CHECK_EN
module stuff_checker (
  input  logic clk,
  input  logic rst_b,
  input  logic i_bit_valid,
  input  logic i_bit,
  input  logic i_clear,
  output logic o_stuff_err
);

  logic [2:0] r_run;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_run       <= 3'd0;
      o_stuff_err <= 1'b0;
    end else if (i_bit_valid) begin
      if (i_bit) begin
        // Six ones already seen: this one is the illegal seventh.
        if (r_run == 3'd6) o_stuff_err <= 1'b1;
        if (r_run != 3'd7) r_run <= r_run + 3'd1;
      end else begin
        r_run <= 3'd0;
      end
    end else if (i_clear) begin
      r_run <= 3'd0;
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/nrzi_encoder.sv
// ==== nrzi_encoder : USB NRZI line encoder with SE0,SE0,J end-of-packet. rev 1.0 ====
// Optional run-length check of encoded ones enabled by macro NRZI_STUFF_CHECK_EN.
`default_nettype none

module nrzi_encoder
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_b,
  input  logic       bstr_in,
  input  logic [1:0] bstr_in_ready,
  output logic       dp,
  output logic       dm,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       stuff_err
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] w_line;
  logic       w_valid;
  logic       w_enc;
  logic       w_overrun_set;

  assign w_valid = (pkt_type_t'(bstr_in_ready) != NONE);

  // w_line is the line level belonging to the state being entered.
  always_comb begin
    w_next        = r_state;
    w_line        = J;
    w_enc         = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_next = DATA;
          w_enc  = 1'b1;
          w_line = bstr_in ? J : K;
        end
      end
      DATA: begin
        if (w_valid) begin
          w_enc  = 1'b1;
          w_line = bstr_in ? {dp, dm} : {dm, dp};
        end else begin
          w_next = EOP1;
          w_line = SE0;
        end
      end
      EOP1: begin
        w_next        = EOP2;
        w_line        = SE0;
        w_overrun_set = w_valid;
      end
      EOP2: begin
        w_next        = EOP_J;
        w_line        = J;
        w_overrun_set = w_valid;
      end
      EOP_J: begin
        w_next        = IDLE;
        w_line        = J;
        w_overrun_set = w_valid;
      end
      default: begin
        w_next = IDLE;
        w_line = J;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      dp      <= 1'b1;
      dm      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      r_state    <= w_next;
      {dp, dm}   <= w_line;
      busy       <= (w_next != IDLE);
      done       <= (r_state == EOP_J);
      if (w_overrun_set) overrun <= 1'b1;
    end
  end

`ifdef NRZI_STUFF_CHECK_EN
  stuff_checker u_stuff_checker (
    .clk         (clk),
    .rst_b       (rst_b),
    .i_bit_valid (w_enc),
    .i_bit       (bstr_in),
    .i_clear     (w_next == IDLE),
    .o_stuff_err (stuff_err)
  );
`else
  assign stuff_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nrzi_encoder.sv
// ==== tb_nrzi_encoder : scoreboard-driven directed and random checks of nrzi_encoder. rev 1.0 ====
`default_nettype none

module tb_nrzi_encoder;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       bstr_in = 1'b0;
  logic [1:0] bstr_in_ready = 2'b00;
  logic       dp, dm, busy, done, overrun, stuff_err;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_done = 0;
  logic exp_ovr = 1'b0;
  logic exp_stuff = 1'b0;

  typedef struct {
    string      tag;
    logic [1:0] line;
    logic       busy;
    logic       done;
    logic       ovr;
    logic       stuff;
  } exp_t;

  exp_t sb[$];

  nrzi_encoder dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .bstr_in       (bstr_in),
    .bstr_in_ready (bstr_in_ready),
    .dp            (dp),
    .dm            (dm),
    .busy          (busy),
    .done          (done),
    .overrun       (overrun),
    .stuff_err     (stuff_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of input, queue what must appear after the next edge, then compare.
  task automatic step(input logic b, input logic [1:0] rdy, input logic [1:0] eline,
                      input logic ebusy, input logic edone, input string tag);
    exp_t e;
    bstr_in       = b;
    bstr_in_ready = rdy;
    sb.push_back('{tag: tag, line: eline, busy: ebusy, done: edone, ovr: exp_ovr, stuff: exp_stuff});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (done === 1'b1) n_done++;
    check({e.tag, ".line"},    8'({dp, dm}),    8'(e.line));
    check({e.tag, ".busy"},    8'(busy),        8'(e.busy));
    check({e.tag, ".done"},    8'(done),        8'(e.done));
    check({e.tag, ".overrun"}, 8'(overrun),     8'(e.ovr));
    check({e.tag, ".stuff"},   8'(stuff_err),   8'(e.stuff));
    check({e.tag, ".no_se1"},  8'(dp & dm),     8'd0);
  endtask

  task automatic eop(input string tag);
    step(1'b0, 2'b00, LSE0, 1'b1, 1'b0, {tag, ".eop1"});
    step(1'b0, 2'b00, LSE0, 1'b1, 1'b0, {tag, ".eop2"});
    step(1'b0, 2'b00, LJ,   1'b1, 1'b0, {tag, ".eopj"});
    step(1'b0, 2'b00, LJ,   1'b0, 1'b1, {tag, ".done"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [1:0] prev;
    logic [1:0] m_line;
    logic       b;
    logic [1:0] r;
    int         run;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.line",    8'({dp, dm}),  8'(LJ));
    check("rst.busy",    8'(busy),      8'd0);
    check("rst.done",    8'(done),      8'd0);
    check("rst.overrun", 8'(overrun),   8'd0);
    check("rst.stuff",   8'(stuff_err), 8'd0);
    rst_b = 1'b1;
    step(1'b0, 2'b00, LJ, 1'b0, 1'b0, "idle");

    // Basic packet 0,0,1,0 -> K,J,J,K then SE0,SE0,J
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "p1.b0");
    step(1'b0, 2'b01, LJ, 1'b1, 1'b0, "p1.b1");
    step(1'b1, 2'b01, LJ, 1'b1, 1'b0, "p1.b2");
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "p1.b3");
    eop("p1");
    step(1'b0, 2'b00, LJ, 1'b0, 1'b0, "p1.idle");

    // Packet-type changes inside DATA keep the packet going
    step(1'b1, 2'b01, LJ, 1'b1, 1'b0, "ty.b0");
    step(1'b0, 2'b11, LK, 1'b1, 1'b0, "ty.b1");
    step(1'b0, 2'b10, LJ, 1'b1, 1'b0, "ty.b2");
    step(1'b1, 2'b01, LJ, 1'b1, 1'b0, "ty.b3");
    // End of packet with a stray bit during EOP1
    step(1'b0, 2'b00, LSE0, 1'b1, 1'b0, "ov.eop1");
    exp_ovr = 1'b1;
    step(1'b1, 2'b10, LSE0, 1'b1, 1'b0, "ov.drop");
    step(1'b0, 2'b00, LJ,   1'b1, 1'b0, "ov.eopj");
    step(1'b0, 2'b00, LJ,   1'b0, 1'b1, "ov.done");
    // Overrun sticks through the next packet
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "ov.p2");
    eop("ov.p2");

    // Back-to-back packets: second starts in the IDLE cycle right after EOP_J
    n_done = 0;
    step(1'b1, 2'b01, LJ, 1'b1, 1'b0, "b2b.a0");
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "b2b.a1");
    eop("b2b.a");
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "b2b.first");
    step(1'b1, 2'b01, LK, 1'b1, 1'b0, "b2b.b1");
    eop("b2b.b");
    check("b2b.done_count", 8'(n_done), 8'd2);

    // Asynchronous reset in EOP2
    step(1'b1, 2'b01, LJ,   1'b1, 1'b0, "ar.b0");
    step(1'b0, 2'b00, LSE0, 1'b1, 1'b0, "ar.eop1");
    step(1'b0, 2'b00, LSE0, 1'b1, 1'b0, "ar.eop2");
    #3;
    rst_b = 1'b0;
    #1;
    check("ar.line",    8'({dp, dm}), 8'(LJ));
    check("ar.busy",    8'(busy),     8'd0);
    check("ar.done",    8'(done),     8'd0);
    check("ar.overrun", 8'(overrun),  8'd0);
    n_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    check("ar.no_done", 8'(n_done), 8'd0);
    check("ar.hold_line", 8'({dp, dm}), 8'(LJ));
    rst_b   = 1'b1;
    exp_ovr = 1'b0;
    step(1'b0, 2'b00, LJ, 1'b0, 1'b0, "ar.idle");

    // Random 64-bit stuffed stream, encoded by the bench and decoded back from the line
    prev   = LJ;
    m_line = LJ;
    run    = 0;
    for (int i = 0; i < 64; i++) begin
      b = 1'($urandom_range(0, 1));
      if (run == 6) b = 1'b0;
      run = b ? run + 1 : 0;
      r = 2'($urandom_range(1, 3));
      if (!b) m_line = ~m_line;
      step(b, r, m_line, 1'b1, 1'b0, "rnd");
      check("rnd.decode", 8'(({dp, dm} == prev)), 8'(b));
      prev = {dp, dm};
    end
    eop("rnd");

    // Run of six ones then a zero, then seven ones
    for (int i = 0; i < 6; i++) step(1'b1, 2'b01, LJ, 1'b1, 1'b0, "run6");
    step(1'b0, 2'b01, LK, 1'b1, 1'b0, "run6.zero");
    for (int i = 0; i < 7; i++) begin
`ifdef NRZI_STUFF_CHECK_EN
      if (i == 6) exp_stuff = 1'b1;
`endif
      step(1'b1, 2'b11, LK, 1'b1, 1'b0, "run7");
    end
    eop("run7");
    step(1'b0, 2'b00, LJ, 1'b0, 1'b0, "run7.sticky");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
